// File: rtl/avmm_master_pkg.sv
// avmm_master_pkg: shared FSM state encoding and counter widths for the PIO master.
package avmm_master_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RESP} state_e;
  localparam int TMO_W = 16;
  localparam int LAT_W = 2;
endpackage

// File: rtl/avmm_timeout_ctr.sv
// avmm_timeout_ctr: counts stalled bus cycles and flags the cycle that reaches LIMIT.
module avmm_timeout_ctr
  import avmm_master_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [TMO_W-1:0] cnt_q;
  // tc fires in the stall cycle whose increment would land on LIMIT
  assign tc = en && (cnt_q == TMO_W'(LIMIT - 1));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/avmm_pio_master.sv
// avmm_pio_master: single-outstanding command/response to Avalon-MM master with wait-state timeout.
module avmm_pio_master
  import avmm_master_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);
  state_e             state_q, state_d;
  logic               write_q, cs_q, cs_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic               rdy_q, rdy_d, err_q, err_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic               accept, stall, tmo, wr_cur, leave_acc;

  assign accept = state_q == IDLE && rdy_q && cmd_valid;
  assign stall  = state_q == ACCESS && avm_waitrequest;
  assign wr_cur = accept ? cmd_write : write_q;

  avmm_timeout_ctr #(.LIMIT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (stall),
    .tc      (tmo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? ACCESS : IDLE;
      ACCESS:  state_d = !avm_waitrequest ? ((write_q || READ_LATENCY == 0) ? RESP : RD_WAIT)
                                          : (tmo ? RESP : ACCESS);
      RD_WAIT: state_d = lat_q == LAT_W'(1) ? RESP : RD_WAIT;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // Every registered output is computed from the upcoming state so it lines up with it.
  always_comb begin
    leave_acc = state_q == ACCESS && state_d != ACCESS;
    cs_d      = state_d == ACCESS;
    wr_n_d    = !(cs_d && wr_cur);
    rd_n_d    = !(cs_d && !wr_cur);
    addr_d    = accept ? cmd_address : addr_q;
    wdata_d   = accept ? cmd_writedata : wdata_q;
    lat_d     = leave_acc ? LAT_W'(READ_LATENCY) : (state_q == RD_WAIT ? lat_q - 1'b1 : lat_q);
    rdata_d   = leave_acc ? ((stall || write_q || READ_LATENCY != 0) ? '0 : avm_readdata)
                          : ((state_q == RD_WAIT && state_d == RESP) ? avm_readdata : rdata_q);
    err_d     = leave_acc ? stall : (state_q == RD_WAIT ? 1'b0 : err_q);
    rdy_d     = state_d == IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q <= 1'b0;
      cs_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      lat_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      write_q <= wr_cur;
      cs_q    <= cs_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign cmd_ready      = rdy_q;
  assign rsp_valid      = state_q == RESP;
  assign rsp_readdata   = rdata_q;
  assign rsp_error      = err_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wr_n_q;
  assign avm_read_n     = rd_n_q;
  assign avm_writedata  = wdata_q;
endmodule
